// File: rtl/dffrs_seq_pkg.sv
// Shared state encoding and sizing helpers for the dffrs reset/set sequencer.
package dffrs_seq_pkg;

    typedef enum logic [2:0] {
        ST_RSYNC   = 3'd0,
        ST_PWR_REL = 3'd1,
        ST_IDLE    = 3'd2,
        ST_ASSERT  = 3'd3,
        ST_REL     = 3'd4
    } state_e;

    // One extra bit over the largest load keeps the down-counter simple to size.
    function automatic int cnt_width(input int gap, input int pulse);
        int m;
        m = (gap > pulse) ? gap : pulse;
        return $clog2(m) + 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dffrs_rst_sync.sv
// Two-flop reset synchronizer: asserts asynchronously with R, releases on the clock.
module dffrs_rst_sync (
    input  logic clk,
    input  logic R,
    output logic sync_n
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = 1'b1;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_n = sync_q;

endmodule

// File: rtl/dffrs_init_seq.sv
// Sequences the active-low R/S pins of NUM_GRP flop groups: staged power-up
// release, then runtime re-initialisation of selected groups to 0 or 1.
module dffrs_init_seq
    import dffrs_seq_pkg::*;
#(
    parameter int NUM_GRP   = 4,
    parameter int GAP_CYC   = 2,
    parameter int PULSE_CYC = 2
) (
    input  logic               clk,
    input  logic               R,
    input  logic               req,
    input  logic [NUM_GRP-1:0] req_mask,
    input  logic [NUM_GRP-1:0] req_val,
    output logic               ack,
    output logic               busy,
    output logic               ready,
    output logic [NUM_GRP-1:0] grp_r_n,
    output logic [NUM_GRP-1:0] grp_s_n
);

    localparam int CNT_W = cnt_width(GAP_CYC, PULSE_CYC);
    localparam int IDX_W = idx_width(NUM_GRP);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);

    state_e             state_q, state_d, cur_st;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_GRP-1:0] rem_q, rem_d;
    logic [NUM_GRP-1:0] val_q, val_d;
    logic [NUM_GRP-1:0] grp_r_n_q, grp_r_n_d;
    logic [NUM_GRP-1:0] grp_s_n_q, grp_s_n_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               ack_q, ack_d;
    logic               sync_n;
    logic [IDX_W-1:0]   nxt_idx;

    function automatic logic [IDX_W-1:0] ffs(input logic [NUM_GRP-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_GRP - 1; i >= 0; i--) begin
            if (m[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    dffrs_rst_sync u_sync (
        .clk    (clk),
        .R      (R),
        .sync_n (sync_n)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        val_d     = val_q;
        grp_r_n_d = grp_r_n_q;
        grp_s_n_d = grp_s_n_q;
        busy_d    = busy_q;
        ready_d   = ready_q;
        ack_d     = 1'b0;
        nxt_idx   = ffs(rem_q);
        // The synchronizer's release edge is the entry into PWR_REL; the counter already holds GAP_LD.
        cur_st    = (state_q == ST_RSYNC && sync_n) ? ST_PWR_REL : state_q;

        case (cur_st)
            ST_RSYNC: rem_d = '1;
            ST_PWR_REL, ST_REL: begin
                state_d = cur_st;
                if (rem_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    if (cur_st == ST_PWR_REL) ready_d = 1'b1;
                    else                      ack_d   = 1'b1;
                end else if (cnt_q == '0) begin
                    if (val_q[nxt_idx]) grp_s_n_d[nxt_idx] = 1'b1;
                    else                grp_r_n_d[nxt_idx] = 1'b1;
                    rem_d[nxt_idx] = 1'b0;
                    cnt_d          = GAP_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (req) begin
                    if (req_mask == '0) begin
                        // Empty request: pass through REL with nothing left so ack lands next edge.
                        state_d = ST_REL;
                        rem_d   = '0;
                    end else begin
                        state_d   = ST_ASSERT;
                        rem_d     = req_mask;
                        val_d     = req_val;
                        busy_d    = 1'b1;
                        cnt_d     = PULSE_LD;
                        grp_r_n_d = grp_r_n_q & ~(req_mask & ~req_val);
                        grp_s_n_d = grp_s_n_q & ~(req_mask & req_val);
                    end
                end
            end
            ST_ASSERT: begin
                if (cnt_q == '0) begin
                    state_d = ST_REL;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_RSYNC;
        endcase
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q   <= ST_RSYNC;
            cnt_q     <= GAP_LD;
            rem_q     <= '0;
            val_q     <= '0;
            grp_r_n_q <= '0;
            grp_s_n_q <= '1;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            val_q     <= val_d;
            grp_r_n_q <= grp_r_n_d;
            grp_s_n_q <= grp_s_n_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            ack_q     <= ack_d;
        end
    end

    assign grp_r_n = grp_r_n_q;
    assign grp_s_n = grp_s_n_q;
    assign busy    = busy_q;
    assign ready   = ready_q;
    assign ack     = ack_q;

endmodule
